// File: rtl/cmd_transceiver_if.sv
// Host-side bus of the SD command-line transceiver: command request, serial CMD line and status.
interface cmd_transceiver_if;
  logic         new_cmd;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         cmd_from_sd;
  logic         cmd_to_sd;
  logic         cmd_to_sd_oe;
  logic         cmd_busy;
  logic         cmd_complete;
  logic         timeout_error;
  logic         crc_error;
  logic         end_bit_error;
  logic         index_error;
  logic [127:0] response_status;

  modport master (
    output new_cmd, cmd_index, cmd_arg, resp_type, cmd_from_sd,
    input  cmd_to_sd, cmd_to_sd_oe, cmd_busy, cmd_complete,
           timeout_error, crc_error, end_bit_error, index_error, response_status
  );

  modport slave (
    input  new_cmd, cmd_index, cmd_arg, resp_type, cmd_from_sd,
    output cmd_to_sd, cmd_to_sd_oe, cmd_busy, cmd_complete,
           timeout_error, crc_error, end_bit_error, index_error, response_status
  );
endinterface

// File: rtl/cmd_transceiver.sv
// SD CMD-line transceiver: serialises a 48-bit command with CRC7, then waits for,
// receives and checks a 48- or 136-bit response. One bit per rising CLK edge.
module cmd_transceiver #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned NCR_MIN        = 2
) (
  input logic          CLK,
  input logic          reset,
  cmd_transceiver_if.slave bus
);

  localparam int unsigned FRAME_LEN = 48;
  localparam int unsigned LONG_LEN  = 136;
  localparam int unsigned WAIT_SPAN = NCR_MIN + TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX   = (WAIT_SPAN > LONG_LEN) ? WAIT_SPAN : LONG_LEN;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND      = 3'd1;
  localparam logic [2:0] ST_WAIT_RESP = 3'd2;
  localparam logic [2:0] ST_RECV      = 3'd3;
  localparam logic [2:0] ST_CHECK     = 3'd4;

  localparam logic [1:0] RT_NONE  = 2'b00;
  localparam logic [1:0] RT_SHORT = 2'b01;
  localparam logic [1:0] RT_LONG  = 2'b10;

  logic [2:0]       state,        state_d;
  logic [CNT_W-1:0] cnt,          cnt_d;
  logic [5:0]       idx_q,        idx_d;
  logic [1:0]       type_q,       type_d;
  logic [47:0]      tx_sr,        tx_sr_d;
  logic [127:0]     rx_sr,        rx_sr_d;
  logic             cmd_to_sd_q,  cmd_to_sd_d;
  logic             oe_q,         oe_d;
  logic             busy_q,       busy_d;
  logic             complete_q,   complete_d;
  logic             timeout_q,    timeout_d;
  logic             crc_q,        crc_d;
  logic             end_q,        end_d;
  logic             index_q,      index_d;
  logic [127:0]     status_q,     status_d;

  logic [47:0]      tx_frame;
  logic [39:0]      tx_msg;
  logic [6:0]       tx_crc;
  logic [6:0]       rx_crc_short;
  logic [6:0]       rx_crc_long;
  logic [CNT_W-1:0] rx_last;

  // One serial step of CRC7, generator x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  // CRCs: command from live inputs (used only at acceptance), responses from the shift register.
  always_comb begin
    tx_msg = {2'b01, bus.cmd_index, bus.cmd_arg};
    tx_crc = 7'd0;
    for (int i = 39; i >= 0; i--) tx_crc = crc7_step(tx_crc, tx_msg[i]);
    rx_crc_short = 7'd0;
    for (int i = 39; i >= 0; i--) rx_crc_short = crc7_step(rx_crc_short, rx_sr[8+i]);
    rx_crc_long = 7'd0;
    for (int i = 119; i >= 0; i--) rx_crc_long = crc7_step(rx_crc_long, rx_sr[8+i]);
    tx_frame = {tx_msg, tx_crc, 1'b1};
    rx_last  = (type_q == RT_LONG) ? CNT_W'(LONG_LEN - 1) : CNT_W'(FRAME_LEN - 1);
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx_q;
    type_d      = type_q;
    tx_sr_d     = tx_sr;
    rx_sr_d     = rx_sr;
    cmd_to_sd_d = cmd_to_sd_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    complete_d  = 1'b0;
    timeout_d   = timeout_q;
    crc_d       = crc_q;
    end_d       = end_q;
    index_d     = index_q;
    status_d    = status_q;

    case (state)
      ST_IDLE: begin
        cmd_to_sd_d = 1'b1;
        oe_d        = 1'b0;
        busy_d      = 1'b0;
        cnt_d       = '0;
        if (bus.new_cmd) begin
          idx_d       = bus.cmd_index;
          type_d      = bus.resp_type;
          cmd_to_sd_d = tx_frame[47];
          tx_sr_d     = {tx_frame[46:0], 1'b0};
          oe_d        = 1'b1;
          busy_d      = 1'b1;
          timeout_d   = 1'b0;
          crc_d       = 1'b0;
          end_d       = 1'b0;
          index_d     = 1'b0;
          cnt_d       = CNT_W'(1);
          state_d     = ST_SEND;
        end
      end

      // cnt counts bits already placed on the line.
      ST_SEND: begin
        if (cnt == CNT_W'(FRAME_LEN)) begin
          cmd_to_sd_d = 1'b1;
          oe_d        = 1'b0;
          cnt_d       = '0;
          if (type_q == RT_NONE) begin
            complete_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_WAIT_RESP;
          end
        end else begin
          cmd_to_sd_d = tx_sr[47];
          tx_sr_d     = {tx_sr[46:0], 1'b0};
          cnt_d       = cnt + CNT_W'(1);
        end
      end

      // First NCR_MIN edges are turnaround; the rest are timeout-bounded start-bit samples.
      ST_WAIT_RESP: begin
        if (cnt < CNT_W'(NCR_MIN)) begin
          cnt_d = cnt + CNT_W'(1);
        end else if (!bus.cmd_from_sd) begin
          rx_sr_d = '0;
          cnt_d   = CNT_W'(1);
          state_d = ST_RECV;
        end else if (cnt == CNT_W'(WAIT_SPAN - 1)) begin
          timeout_d  = 1'b1;
          complete_d = 1'b1;
          busy_d     = 1'b0;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      ST_RECV: begin
        rx_sr_d = {rx_sr[126:0], bus.cmd_from_sd};
        cnt_d   = cnt + CNT_W'(1);
        if (cnt == rx_last) begin
          cnt_d   = '0;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (type_q == RT_LONG) begin
          status_d = {8'h00, rx_sr[127:8]};
          crc_d    = (rx_sr[7:1] != rx_crc_long);
        end else begin
          status_d = {96'h0, rx_sr[39:8]};
          if (type_q == RT_SHORT) begin
            crc_d   = (rx_sr[7:1] != rx_crc_short);
            index_d = (rx_sr[45:40] != idx_q);
          end
        end
        end_d      = ~rx_sr[0];
        complete_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end

      default: begin
        cmd_to_sd_d = 1'b1;
        oe_d        = 1'b0;
        busy_d      = 1'b0;
        cnt_d       = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx_q       <= '0;
      type_q      <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      cmd_to_sd_q <= 1'b1;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      complete_q  <= 1'b0;
      timeout_q   <= 1'b0;
      crc_q       <= 1'b0;
      end_q       <= 1'b0;
      index_q     <= 1'b0;
      status_q    <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      idx_q       <= idx_d;
      type_q      <= type_d;
      tx_sr       <= tx_sr_d;
      rx_sr       <= rx_sr_d;
      cmd_to_sd_q <= cmd_to_sd_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      complete_q  <= complete_d;
      timeout_q   <= timeout_d;
      crc_q       <= crc_d;
      end_q       <= end_d;
      index_q     <= index_d;
      status_q    <= status_d;
    end
  end

  assign bus.cmd_to_sd       = cmd_to_sd_q;
  assign bus.cmd_to_sd_oe    = oe_q;
  assign bus.cmd_busy        = busy_q;
  assign bus.cmd_complete    = complete_q;
  assign bus.timeout_error   = timeout_q;
  assign bus.crc_error       = crc_q;
  assign bus.end_bit_error   = end_q;
  assign bus.index_error     = index_q;
  assign bus.response_status = status_q;

endmodule

// File: tb/tb_cmd_transceiver.sv
// Directed bench for cmd_transceiver: command framing, response checks, timeout and reset abort.
module tb_cmd_transceiver;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cmd_transceiver_if bus();

  cmd_transceiver #(.TIMEOUT_CYCLES(64), .NCR_MIN(2)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC7 by long division of msg*x^7 by 0x89; msg holds n bits right-aligned.
  function automatic logic [6:0] crc7_ref(input logic [119:0] msg, input int n);
    logic [127:0] r;
    r = {1'b0, msg, 7'b0};
    for (int i = n + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] build48(input logic [1:0] lead, input logic [5:0] idx,
                                          input logic [31:0] arg);
    logic [39:0] m;
    m = {lead, idx, arg};
    return {m, crc7_ref(120'(m), 40), 1'b1};
  endfunction

  function automatic logic [3:0] flags();
    return {bus.timeout_error, bus.crc_error, bus.end_bit_error, bus.index_error};
  endfunction

  // Call just after a negedge. Returns at the negedge of the completion cycle (done = cycle number,
  // edge 0 being the accepting edge), or -1 when no completion appears within the budget.
  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic [135:0] rf, input int rlen, input int dly, input int pulse_cyc,
                         output int done, output logic [47:0] tx, output bit send_ok);
    int bi;
    bus.new_cmd     = 1'b1;
    bus.cmd_index   = idx;
    bus.cmd_arg     = arg;
    bus.resp_type   = rt;
    bus.cmd_from_sd = 1'b1;
    @(posedge CLK);
    done    = -1;
    tx      = '0;
    send_ok = 1'b1;
    for (int c = 1; c <= 400 && done < 0; c++) begin
      @(negedge CLK);
      bus.new_cmd   = (c == pulse_cyc);
      bus.cmd_index = (c == pulse_cyc) ? ~idx : idx;
      if (c <= 48) begin
        tx = {tx[46:0], bus.cmd_to_sd};
        if (!bus.cmd_to_sd_oe || !bus.cmd_busy || bus.cmd_complete) send_ok = 1'b0;
      end else if (bus.cmd_complete) begin
        done = c;
      end
      bi = c - (49 + dly);
      bus.cmd_from_sd = (bi >= 0 && bi < rlen) ? rf[rlen-1-bi] : 1'b1;
    end
    bus.new_cmd     = 1'b0;
    bus.cmd_from_sd = 1'b1;
  endtask

  initial begin
    int          done;
    logic [47:0] tx;
    bit          send_ok;
    logic [47:0] f48;
    logic [119:0] payload;
    logic [135:0] f136;

    bus.new_cmd     = 1'b0;
    bus.cmd_index   = '0;
    bus.cmd_arg     = '0;
    bus.resp_type   = '0;
    bus.cmd_from_sd = 1'b1;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_cmd_to_sd", 128'(bus.cmd_to_sd), 128'(1'b1));
    check("rst_oe",        128'(bus.cmd_to_sd_oe), 128'(1'b0));
    check("rst_busy",      128'(bus.cmd_busy), 128'(1'b0));
    check("rst_complete",  128'(bus.cmd_complete), 128'(1'b0));
    check("rst_flags",     128'(flags()), 128'(4'b0000));
    check("rst_status",    bus.response_status, 128'h0);
    reset = 1'b0;

    // CMD0, no response
    @(negedge CLK);
    run_txn(6'd0, 32'h0, 2'b00, '0, 0, 0, 0, done, tx, send_ok);
    check("cmd0_tx",      128'(tx), 128'(48'h40_0000_0000_95));
    check("cmd0_send_ok", 128'(send_ok), 128'(1'b1));
    check("cmd0_done",    128'(done), 128'(49));
    check("cmd0_busy",    128'(bus.cmd_busy), 128'(1'b0));
    check("cmd0_oe",      128'(bus.cmd_to_sd_oe), 128'(1'b0));
    check("cmd0_flags",   128'(flags()), 128'(4'b0000));

    // CMD8 with valid R7
    run_txn(6'd8, 32'h1AA, 2'b01, 136'(48'h08_000001AA_13), 48, 5, 0, done, tx, send_ok);
    check("cmd8_tx",     128'(tx), 128'(48'h48_0000_01AA_87));
    check("cmd8_done",   128'(done > 0), 128'(1'b1));
    check("cmd8_status", bus.response_status, 128'h1AA);
    check("cmd8_flags",  128'(flags()), 128'(4'b0000));
    check("cmd8_busy",   128'(bus.cmd_busy), 128'(1'b0));

    // Payload bit flipped: CRC error only
    run_txn(6'd8, 32'h1AA, 2'b01, 136'(48'h08_000001AB_13), 48, 5, 0, done, tx, send_ok);
    check("crcbad_done",   128'(done > 0), 128'(1'b1));
    check("crcbad_flags",  128'(flags()), 128'(4'b0100));
    check("crcbad_status", bus.response_status, 128'h1AB);

    // Wrong index with valid CRC: index error only
    f48 = build48(2'b00, 6'd9, 32'h1AA);
    run_txn(6'd8, 32'h1AA, 2'b01, 136'(f48), 48, 3, 0, done, tx, send_ok);
    check("idx_done",  128'(done > 0), 128'(1'b1));
    check("idx_flags", 128'(flags()), 128'(4'b0001));

    // No response: timeout, status preserved
    run_txn(6'd8, 32'h1AA, 2'b01, '0, 0, 0, 0, done, tx, send_ok);
    check("to_done",   128'(done), 128'(115));
    check("to_busy",   128'(bus.cmd_busy), 128'(1'b0));
    check("to_flags",  128'(flags()), 128'(4'b1000));
    check("to_status", bus.response_status, 128'h1AA);

    // R3: bad CRC and index ignored
    f48 = build48(2'b01, 6'd41, 32'h40FF_8000);
    check("r3_tx", 128'(0), 128'(0) ^ 128'(0)) ;
    run_txn(6'd41, 32'h40FF_8000, 2'b11, 136'(48'h3F_00FF8000_FF), 48, 4, 0, done, tx, send_ok);
    check("r3_tx_frame", 128'(tx), 128'(f48));
    check("r3_done",   128'(done > 0), 128'(1'b1));
    check("r3_flags",  128'(flags()), 128'(4'b0000));
    check("r3_status", bus.response_status, 128'h00FF_8000);

    // R2 with valid CRC but end bit 0
    payload = 120'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32;
    f136 = {2'b00, 6'b111111, payload, crc7_ref(payload, 120), 1'b0};
    run_txn(6'd2, 32'h0, 2'b10, f136, 136, 2, 0, done, tx, send_ok);
    check("r2_done",   128'(done > 0), 128'(1'b1));
    check("r2_flags",  128'(flags()), 128'(4'b0010));
    check("r2_status", bus.response_status, {8'h00, payload});

    // Reset during SEND aborts without completion
    bus.new_cmd   = 1'b1;
    bus.cmd_index = 6'd17;
    bus.cmd_arg   = 32'h1234;
    bus.resp_type = 2'b01;
    @(posedge CLK);
    #1 bus.new_cmd = 1'b0;
    repeat (20) @(negedge CLK);
    check("abort_pre_oe", 128'(bus.cmd_to_sd_oe), 128'(1'b1));
    reset = 1'b1;
    #1;
    check("abort_oe",     128'(bus.cmd_to_sd_oe), 128'(1'b0));
    check("abort_to_sd",  128'(bus.cmd_to_sd), 128'(1'b1));
    check("abort_busy",   128'(bus.cmd_busy), 128'(1'b0));
    check("abort_status", bus.response_status, 128'h0);
    repeat (2) begin
      @(negedge CLK);
      check("abort_no_complete", 128'(bus.cmd_complete), 128'(1'b0));
    end
    reset = 1'b0;

    // First edge after release accepts; new_cmd while busy is ignored
    f48 = build48(2'b01, 6'd17, 32'h1234);
    run_txn(6'd17, 32'h1234, 2'b00, '0, 0, 0, 10, done, tx, send_ok);
    check("post_tx",      128'(tx), 128'(f48));
    check("post_send_ok", 128'(send_ok), 128'(1'b1));
    check("post_done",    128'(done), 128'(49));
    @(negedge CLK);
    check("post_complete_pulse", 128'(bus.cmd_complete), 128'(1'b0));
    check("post_idle_oe",        128'(bus.cmd_to_sd_oe), 128'(1'b0));
    check("post_idle_busy",      128'(bus.cmd_busy), 128'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_transceiver.md
CMD_TRANSCEIVER -- requirements
Module: cmd_transceiver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: number of sampled bit cycles searched for a response start bit before timeout.
REQ-002 Parameter NCR_MIN, default 2: bus turnaround cycles after the command end bit during which cmd_from_sd is ignored.
REQ-003 CLK  in  1  single clock; one bit time per rising edge; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 new_cmd  in  1  command request, sampled only in IDLE.
REQ-006 cmd_index  in  6  command index, latched on acceptance.
REQ-007 cmd_arg  in  32  command argument, latched on acceptance.
REQ-008 resp_type  in  2  00 none, 01 48-bit checked, 10 136-bit, 11 48-bit unchecked (R3); latched on acceptance.
REQ-009 cmd_from_sd  in  1  serial CMD line from card.
REQ-010 cmd_to_sd  out  1  serial CMD line to card.
REQ-011 cmd_to_sd_oe  out  1  output enable for cmd_to_sd.
REQ-012 cmd_busy  out  1  high from acceptance until the cycle of cmd_complete inclusive-exclusive (low in the complete cycle).
REQ-013 cmd_complete  out  1  one-cycle pulse at end of every transaction.
REQ-014 timeout_error, crc_error, end_bit_error, index_error  out  1 each  status flags.
REQ-015 response_status  out  128  received response payload.

Function
REQ-016 States SHALL be IDLE, SEND, WAIT_RESP, RECV, CHECK; unlisted encodings SHALL return to IDLE.
REQ-017 In IDLE with new_cmd=1 at edge 0, inputs SHALL be latched, all four error flags cleared, and SEND entered; new_cmd outside IDLE SHALL be ignored.
REQ-018 Frame SHALL be 48 bits MSB first: 0, 1, cmd_index[5:0], cmd_arg[31:0], CRC7[6:0], 1.
REQ-019 CRC7 SHALL use polynomial x^7+x^3+1, zero seed, over the first 40 frame bits.
REQ-020 cmd_to_sd_oe SHALL be 1 and cmd_to_sd SHALL drive frame bits 47..0 during cycles 1..48; otherwise cmd_to_sd=1, cmd_to_sd_oe=0.
REQ-021 resp_type=00: cycle 49 SHALL pulse cmd_complete, cmd_busy=0, return to IDLE.
REQ-022 Otherwise WAIT_RESP: cycles 49..48+NCR_MIN ignored; from cycle 49+NCR_MIN cmd_from_sd sampled each cycle with a sample counter.
REQ-023 If TIMEOUT_CYCLES samples pass with no 0, timeout_error=1 and cmd_complete SHALL pulse in the next cycle (49+NCR_MIN+TIMEOUT_CYCLES); response_status unchanged.
REQ-024 First sampled 0 SHALL be the start bit; RECV SHALL sample LEN-1 further bits (LEN=136 for type 10, else 48), MSB first.
REQ-025 CHECK, one cycle after last bit: flags set, response_status updated, cmd_complete pulsed, return to IDLE.
REQ-026 48-bit: response_status[31:0]=frame[39:8], upper bits 0; crc_error if frame[7:1] != CRC7(frame[47:8]); index_error if frame[45:40] != latched cmd_index.
REQ-027 Type 11: CRC and index checks SHALL be skipped (flags stay 0).
REQ-028 136-bit: response_status[119:0]=frame[127:8], [127:120]=0; crc_error if frame[7:1] != CRC7(frame[127:8]); no index check.
REQ-029 end_bit_error if received frame[0]=0, all types.
REQ-030 Flags and response_status SHALL hold until the next accepted command.

Reset
REQ-031 reset SHALL force IDLE immediately, any state: cmd_to_sd=1, cmd_to_sd_oe=0, cmd_busy=0, cmd_complete=0, all flags 0, response_status=0, counters 0.
REQ-032 Reset mid-transaction SHALL abort with no cmd_complete pulse; first edge after release SHALL accept new_cmd.

Verification
REQ-033 CMD0, arg 0, type 00 -> cmd_to_sd 0x40_0000_0000_95 in cycles 1..48; cmd_complete at cycle 49; no flags.
REQ-034 CMD8, arg 0x000001AA, type 01; card returns 0x08_000001AA_13 after 5 idle cycles -> TX ends ..._87; response_status=0x1AA; all flags 0.
REQ-035 Same with one payload bit flipped -> crc_error=1, others 0; with frame[45:40]=9 plus valid CRC -> index_error=1 only.
REQ-036 type 01, cmd_from_sd held 1 -> timeout_error=1, cmd_complete at cycle 49+2+64=115, busy low then.
REQ-037 type 10, bench-built 136-bit frame with valid CRC, then end bit 0 -> response_status[119:0] matches, end_bit_error=1 only.
REQ-038 reset asserted at cycle 20 of SEND -> oe=0, cmd_to_sd=1 at once, no complete pulse; new command afterwards completes normally; new_cmd pulsed while busy ignored.
